// File: rtl/alu_result_stage_if.sv
// ----------------------------------------------------------------------------
// alu_result_stage_if
//
// Purpose:
//   Groups the ALU-side input handshake and the register-file-side writeback
//   handshake of alu_result_stage into one bundle.
//
// Signals:
//   in_valid / in_ready      ALU result handshake (producer -> stage)
//   in_result                ALU result, W bits
//   in_co, in_n, in_v, in_z  ALU flags
//   in_mode, in_op           ALU mode and opcode of the producing operation
//   in_rd, in_we             destination register and register write flag
//   out_valid / out_ready    writeback handshake (stage -> register file)
//   wb_data, wb_rd, wb_we    head entry of the stage buffer
//
// Modports:
//   slave   the stage itself (consumes in_*, out_ready; drives the rest)
//   master  the surrounding pipeline / testbench side
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface alu_result_stage_if #(
    parameter int W  = 17,
    parameter int RA = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_result;
    logic          in_co;
    logic          in_n;
    logic          in_v;
    logic          in_z;
    logic          in_mode;
    logic [2:0]    in_op;
    logic [RA-1:0] in_rd;
    logic          in_we;

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  wb_data;
    logic [RA-1:0] wb_rd;
    logic          wb_we;

    modport slave (
        input  in_valid, in_result, in_co, in_n, in_v, in_z,
               in_mode, in_op, in_rd, in_we, out_ready,
        output in_ready, out_valid, wb_data, wb_rd, wb_we
    );

    modport master (
        output in_valid, in_result, in_co, in_n, in_v, in_z,
               in_mode, in_op, in_rd, in_we, out_ready,
        input  in_ready, out_valid, wb_data, wb_rd, wb_we
    );
endinterface

// File: rtl/alu_result_stage.sv
// ----------------------------------------------------------------------------
// alu_result_stage
//
// Purpose:
//   Execute-to-writeback stage behind the ALU. Each accepted ALU result is
//   placed in a 2-entry FIFO and presented to the register file. The stage
//   also owns the architectural flag register {N,Z,CO,V}, evaluates branch
//   conditions against it, flags illegal opcodes and counts retired ops.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   bus         alu_result_stage_if.slave (input and writeback handshakes)
//   cond        branch condition code
//   flags_q     architectural flags {N,Z,CO,V}
//   cond_true   cond evaluated on flags_q (combinational)
//   illegal_op  sticky, set when op 6/7 is accepted
//   retired     count of accepted operations, wraps
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_result_stage #(
    parameter int W  = 17,
    parameter int RA = 3,
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_result_stage_if.slave   bus,
    input  logic [3:0]          cond,
    output logic [3:0]          flags_q,
    output logic                cond_true,
    output logic                illegal_op,
    output logic [CW-1:0]       retired
);

    typedef struct packed {
        logic [W-1:0]  data;
        logic [RA-1:0] rd;
        logic          we;
    } entry_t;

    entry_t        mem_q [0:1];
    entry_t        mem_d [0:1];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic [3:0]    flags_d;
    logic          illegal_q, illegal_d;
    logic [CW-1:0] retired_q, retired_d;

    logic          push;
    logic          pop;
    logic          op_illegal;
    logic          op_addsub;

    // Handshake status depends on the count register only, so in_ready
    // never combinationally follows out_ready.
    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.wb_data   = mem_q[rd_ptr_q].data;
    assign bus.wb_rd     = mem_q[rd_ptr_q].rd;
    assign bus.wb_we     = mem_q[rd_ptr_q].we & bus.out_valid;

    assign illegal_op    = illegal_q;
    assign retired       = retired_q;

    // Next-state logic for buffer, flags, sticky illegal bit and counter.
    // A push never overwrites the head while it is still valid: with one
    // entry held, the write pointer already points at the other slot.
    always_comb begin
        push       = bus.in_valid & bus.in_ready;
        pop        = bus.out_valid & bus.out_ready;
        op_illegal = (bus.in_op >= 3'd6);
        op_addsub  = (bus.in_op == 3'd0) || (bus.in_op == 3'd1);

        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q ^ pop;
        wr_ptr_d   = wr_ptr_q ^ push;
        count_d    = count_q;
        flags_d    = flags_q;
        illegal_d  = illegal_q;
        retired_d  = retired_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (push) begin
            mem_d[wr_ptr_q].data = bus.in_result;
            mem_d[wr_ptr_q].rd   = bus.in_rd;
            mem_d[wr_ptr_q].we   = bus.in_we & ~op_illegal;
            retired_d            = retired_q + CW'(1);

            if (op_illegal) begin
                illegal_d = 1'b1;
            end else if (!bus.in_mode) begin
                // Shift-mode N/Z are not meaningful, so only arith/logic
                // ops touch the flags; logic ops keep CO and V.
                if (op_addsub) begin
                    flags_d = {bus.in_n, bus.in_z, bus.in_co, bus.in_v};
                end else begin
                    flags_d = {bus.in_n, bus.in_z, flags_q[1:0]};
                end
            end
        end
    end

    // State registers; reset empties the buffer and clears the head
    // storage so wb_* read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q     <= '{default: '0};
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            flags_q   <= 4'd0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Branch condition evaluation on the architectural flags.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = flags_q[2];
            4'd2:    cond_true = ~flags_q[2];
            4'd3:    cond_true = flags_q[1];
            4'd4:    cond_true = ~flags_q[1];
            4'd5:    cond_true = flags_q[3];
            4'd6:    cond_true = ~flags_q[3];
            4'd7:    cond_true = flags_q[0];
            4'd8:    cond_true = ~flags_q[0];
            4'd9:    cond_true = (flags_q[3] == flags_q[0]);
            4'd10:   cond_true = (flags_q[3] != flags_q[0]);
            4'd11:   cond_true = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'd12:   cond_true = flags_q[2] | (flags_q[3] != flags_q[0]);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_result_stage
//
// Purpose:
//   Directed testbench for alu_result_stage. Expected writeback entries are
//   queued when a push is issued and a separate monitor compares them as the
//   stage presents and hands off each head entry.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_result_stage;

    localparam int W  = 17;
    localparam int RA = 3;
    localparam int CW = 16;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [RA-1:0] rd;
        logic          we;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    cond;
    logic [3:0]    flags_q;
    logic          cond_true;
    logic          illegal_op;
    logic [CW-1:0] retired;

    exp_t          expQ [$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] expRetired = '0;

    alu_result_stage_if #(.W(W), .RA(RA)) bus ();

    alu_result_stage #(.W(W), .RA(RA), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cond       (cond),
        .flags_q    (flags_q),
        .cond_true  (cond_true),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Presents one ALU result, waits (bounded) for acceptance and queues the
    // expected writeback entry. Starts and ends just after a rising edge.
    task automatic applyStimulus(input logic [W-1:0] res, input logic n,
                                 input logic z, input logic co, input logic v,
                                 input logic mode, input logic [2:0] op,
                                 input logic [RA-1:0] rd, input logic we);
        int   waitCycles;
        exp_t e;
        waitCycles    = 0;
        bus.in_valid  = 1'b1;
        bus.in_result = res;
        bus.in_n      = n;
        bus.in_z      = z;
        bus.in_co     = co;
        bus.in_v      = v;
        bus.in_mode   = mode;
        bus.in_op     = op;
        bus.in_rd     = rd;
        bus.in_we     = we;
        @(negedge clk);
        while (!bus.in_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!bus.in_ready) begin
            checkOutput("push_timeout", 32'd0, 32'd1);
        end else begin
            e.data = res;
            e.rd   = rd;
            e.we   = we && (op < 3'd6);
            expQ.push_back(e);
            expRetired = expRetired + 1'b1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Walks all 16 condition codes against a hand-computed truth vector.
    task automatic sweepCond(input string name, input logic [15:0] expVec);
        for (int c = 0; c < 16; c++) begin
            cond = 4'(c);
            @(negedge clk);
            checkOutput($sformatf("%s_cond%0d", name, c), 32'(cond_true), 32'(expVec[c]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: each cycle a head entry is handed off, compare against the
    // oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.wb_we && !bus.out_valid)
                checkOutput("wb_we_unqualified", 32'd1, 32'd0);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_wb", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wb_data", 32'(bus.wb_data), 32'(e.data));
                    checkOutput("wb_rd",   32'(bus.wb_rd),   32'(e.rd));
                    checkOutput("wb_we",   32'(bus.wb_we),   32'(e.we));
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        rst           = 1'b1;
        cond          = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_n      = 1'b0;
        bus.in_z      = 1'b0;
        bus.in_co     = 1'b0;
        bus.in_v      = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_rd     = '0;
        bus.in_we     = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid",  32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready",   32'(bus.in_ready),  32'd1);
        checkOutput("rst_wb_data",    32'(bus.wb_data),   32'd0);
        checkOutput("rst_wb_rd",      32'(bus.wb_rd),     32'd0);
        checkOutput("rst_wb_we",      32'(bus.wb_we),     32'd0);
        checkOutput("rst_flags",      32'(flags_q),       32'd0);
        checkOutput("rst_illegal",    32'(illegal_op),    32'd0);
        checkOutput("rst_retired",    32'(retired),       32'd0);
        rst = 1'b0;
        sweepCond("flags0000", 16'h0B55);

        // ADD, zero result with carry.
        $display("[TB] ADD with Z and CO");
        bus.out_ready = 1'b1;
        applyStimulus(17'h00000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 1'b1);
        checkOutput("add_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("add_flags",     32'(flags_q),       32'h6);
        checkOutput("add_retired",   32'(retired),       32'(expRetired));
        cond = 4'd1;
        #1;
        checkOutput("add_eq", 32'(cond_true), 32'd1);
        sweepCond("flags0110", 16'h134B);

        // Back-pressure: three pushes against a stalled register file.
        $display("[TB] Back-pressure and ordering");
        bus.out_ready = 1'b0;
        fork
            begin
                applyStimulus(17'h00011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd1, 1'b1);
                applyStimulus(17'h00022, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 1'b1);
                applyStimulus(17'h00033, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd4, 1'b1);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                checkOutput("stall_head_data1", 32'(bus.wb_data), 32'h11);
                @(negedge clk);
                checkOutput("full_in_ready",    32'(bus.in_ready),  32'd0);
                checkOutput("full_out_valid",   32'(bus.out_valid), 32'd1);
                checkOutput("stall_head_data2", 32'(bus.wb_data),   32'h11);
                checkOutput("stall_head_rd",    32'(bus.wb_rd),     32'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                @(negedge clk);
                checkOutput("full_in_ready_indep", 32'(bus.in_ready), 32'd0);
                @(negedge clk);
                checkOutput("after_pop_in_ready",  32'(bus.in_ready), 32'd1);
            end
        join
        waitDrain();
        checkOutput("bp_retired", 32'(retired), 32'(expRetired));
        checkOutput("bp_flags",   32'(flags_q), 32'h6);

        // SUB loads all flags; AND updates N/Z and holds CO/V.
        $display("[TB] SUB then AND flag behaviour");
        applyStimulus(17'h1FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd5, 1'b1);
        checkOutput("sub_flags", 32'(flags_q), 32'hA);
        sweepCond("flags1010", 16'h152D);
        applyStimulus(17'h00100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd6, 1'b1);
        checkOutput("and_flags", 32'(flags_q), 32'h2);
        sweepCond("flags0010", 16'h0B4D);

        // Shift mode writes back but leaves flags alone.
        $display("[TB] Shift mode");
        applyStimulus(17'h1FFFE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 3'd7, 1'b1);
        checkOutput("shift_flags",   32'(flags_q),    32'h2);
        checkOutput("pre_illegal",   32'(illegal_op), 32'd0);

        // Illegal opcodes: buffered with no write, sticky flag.
        $display("[TB] Illegal opcodes");
        applyStimulus(17'h0ABCD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 3'd2, 1'b1);
        checkOutput("ill6_flags",   32'(flags_q),    32'h2);
        checkOutput("ill6_illegal", 32'(illegal_op), 32'd1);
        applyStimulus(17'h00777, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 3'd3, 1'b1);
        checkOutput("ill7_flags",   32'(flags_q),    32'h2);
        applyStimulus(17'h00001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 1'b1);
        checkOutput("post_ill_flags",   32'(flags_q),    32'h0);
        checkOutput("post_ill_illegal", 32'(illegal_op), 32'd1);
        waitDrain();
        checkOutput("ill_retired", 32'(retired), 32'(expRetired));

        // Reset in the middle of a full buffer.
        $display("[TB] Reset mid-stream");
        bus.out_ready = 1'b0;
        applyStimulus(17'h10000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd3, 1'b1);
        applyStimulus(17'h00044, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd4, 1'b1);
        checkOutput("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("pre_rst_flags",    32'(flags_q),      32'hB);
        rst = 1'b1;
        #1;
        expQ.delete();
        expRetired = '0;
        checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("mid_rst_flags",     32'(flags_q),       32'd0);
        checkOutput("mid_rst_retired",   32'(retired),       32'd0);
        checkOutput("mid_rst_illegal",   32'(illegal_op),    32'd0);
        checkOutput("mid_rst_wb_we",     32'(bus.wb_we),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post_rst_out_valid%0d", i), 32'(bus.out_valid), 32'd0);
            checkOutput($sformatf("post_rst_wb_we%0d", i),     32'(bus.wb_we),     32'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(17'h00042, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 1'b1);
        waitDrain();
        checkOutput("final_retired", 32'(retired), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
